writeback_arbiter: RTL and testbench

Merges the two result sources of the datapath, the single-cycle ALU path and the variable-latency load unit, onto the register file's single write port (WE, rd, writeBack). Load results are buffered in a small FIFO and drain into cycles the ALU leaves free. A starvation counter forces an ALU bubble when loads wait too long. A pending-load mask is exported to the hazard unit.

---
 rtl/writeback_arbiter_if.sv | 34 +++
 rtl/writeback_arbiter.sv | 117 +++++++++++
 tb/tb_writeback_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// ============================================================================
// Module      : writeback_arbiter_if
// Description : Handshake and register-file write bundle for writeback_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface writeback_arbiter_if;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        aluReady;
  logic        ldValid;
  logic [4:0]  ldRd;
  logic [31:0] ldData;
  logic        ldReady;
  logic        WE;
  logic [4:0]  rd;
  logic [31:0] writeBack;
  logic        stallALU;
  logic [31:0] busyMask;

  modport slave (
    input  aluValid, aluRd, aluData, ldValid, ldRd, ldData,
    output aluReady, ldReady, WE, rd, writeBack, stallALU, busyMask
  );

  modport master (
    output aluValid, aluRd, aluData, ldValid, ldRd, ldData,
    input  aluReady, ldReady, WE, rd, writeBack, stallALU, busyMask
  );
endinterface

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// ============================================================================
// Module      : writeback_arbiter
// Description : Merges ALU and buffered load results onto one register-file
//               write port, with starvation-driven ALU bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic               CLK,
  input  logic               rstControl,
  writeback_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CW:0] C_STARVE_LIMIT = (CW+1)'(STARVE_MAX - 1);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [4:0]    r_mem_rd   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic          r_we;
  logic [4:0]    r_rd;
  logic [31:0]   r_wb;
  logic          r_stall;
  logic [CW-1:0] r_starve_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_alu_acc;
  logic          w_alu_claim;
  logic          w_push;
  logic          w_pop;
  logic          w_blocked;
  logic          w_starve_hit;
  logic [CW:0]   w_cnt_inc;
  logic [AW:0]   w_count;
  logic [AW-1:0] w_off;
  logic [31:0]   w_busy;

  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_alu_acc    = bus.aluValid & ~r_stall;
  assign w_alu_claim  = w_alu_acc & (bus.aluRd != 5'd0);
  assign w_push       = bus.ldValid & ~w_full & (bus.ldRd != 5'd0);
  assign w_pop        = ~w_alu_claim & ~w_empty;
  assign w_blocked    = w_alu_claim & ~w_empty;
  assign w_cnt_inc    = {1'b0, r_starve_cnt} + (CW+1)'(1);
  assign w_starve_hit = w_blocked & (w_cnt_inc >= C_STARVE_LIMIT);

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr[AW-1:0]]   <= bus.ldRd;
      r_mem_data[r_wr_ptr[AW-1:0]] <= bus.ldData;
    end
  end

  always_ff @(posedge CLK or negedge rstControl) begin
    if (!rstControl) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_we         <= 1'b0;
      r_rd         <= 5'd0;
      r_wb         <= 32'd0;
      r_stall      <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);

      if (w_alu_claim) begin
        r_we <= 1'b1;
        r_rd <= bus.aluRd;
        r_wb <= bus.aluData;
      end else if (w_pop) begin
        r_we <= 1'b1;
        r_rd <= r_mem_rd[r_rd_ptr[AW-1:0]];
        r_wb <= r_mem_data[r_rd_ptr[AW-1:0]];
      end else begin
        r_we <= 1'b0;
      end

      // A forced bubble is always followed by a pop, so it can never repeat back to back.
      r_stall <= w_starve_hit;
      if (w_pop || w_empty || w_starve_hit) r_starve_cnt <= '0;
      else if (w_blocked)                    r_starve_cnt <= w_cnt_inc[CW-1:0];
    end
  end

  always_comb begin
    w_busy  = 32'd0;
    w_count = r_wr_ptr - r_rd_ptr;
    w_off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = AW'(i) - r_rd_ptr[AW-1:0];
      if ({1'b0, w_off} < w_count) w_busy[r_mem_rd[i]] = 1'b1;
    end
    w_busy[0] = 1'b0;
  end

  assign bus.aluReady  = ~r_stall;
  assign bus.ldReady   = ~w_full;
  assign bus.WE        = r_we;
  assign bus.rd        = r_rd;
  assign bus.writeBack = r_wb;
  assign bus.stallALU  = r_stall;
  assign bus.busyMask  = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Self-checking bench: vector table, corner sequences, random run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic CLK = 1'b0;
  logic rstControl;
  always #5 CLK = ~CLK;

  writeback_arbiter_if bus();

  writeback_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK       (CLK),
    .rstControl(rstControl),
    .bus       (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wb;
  bit          m_stall;
  int          m_cnt;

  typedef struct {
    bit          av;
    logic [4:0]  ar;
    logic [31:0] ad;
    bit          lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] wb;
    logic [31:0] busy;
    bit          lrdy;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(bit av, logic [4:0] ar, logic [31:0] ad,
                              bit lv, logic [4:0] lr, logic [31:0] ld,
                              bit we, logic [4:0] rd, logic [31:0] wb,
                              logic [31:0] busy, bit lrdy);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ld = ld;
    v.we = we; v.rd = rd; v.wb = wb; v.busy = busy; v.lrdy = lrdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ld);
    bus.aluValid = av; bus.aluRd = ar; bus.aluData = ad;
    bus.ldValid  = lv; bus.ldRd  = lr; bus.ldData  = ld;
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b = 32'd0;
    foreach (q[i]) b[q[i].rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  // One clock edge of the arbiter, derived from the acceptance/priority rules.
  task automatic model_edge();
    bit   claim, push, pop, stall_next;
    ent_t e;
    claim      = bus.aluValid && !m_stall && (bus.aluRd != 5'd0);
    push       = bus.ldValid && (q.size() < DEPTH) && (bus.ldRd != 5'd0);
    pop        = !claim && (q.size() > 0);
    stall_next = 1'b0;
    if (claim) begin
      m_we = 1'b1; m_rd = bus.aluRd; m_wb = bus.aluData;
    end else if (pop) begin
      m_we = 1'b1; m_rd = q[0].rd; m_wb = q[0].data;
    end else begin
      m_we = 1'b0;
    end
    if (pop || q.size() == 0) m_cnt = 0;
    else if (claim) begin
      m_cnt++;
      if (m_cnt >= STARVE_MAX - 1) begin
        stall_next = 1'b1;
        m_cnt      = 0;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      e.rd = bus.ldRd; e.data = bus.ldData;
      q.push_back(e);
    end
    m_stall = stall_next;
  endtask

  task automatic model_clear();
    q.delete();
    m_we = 1'b0; m_rd = 5'd0; m_wb = 32'd0; m_stall = 1'b0; m_cnt = 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #3 rstControl = 1'b0;
    #1 model_clear();
    @(posedge CLK);
    #1 rstControl = 1'b1;
  endtask

  bit          av, lv, held;
  logic [4:0]  ar, lr;
  logic [31:0] ad, ld;

  initial begin
    rstControl = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    model_clear();
    #1 rstControl = 1'b0;
    #1;
    chk("reset_we",      32'(bus.WE),        32'd0);
    chk("reset_rd",      32'(bus.rd),        32'd0);
    chk("reset_wb",      bus.writeBack,      32'd0);
    chk("reset_stall",   32'(bus.stallALU),  32'd0);
    chk("reset_busy",    bus.busyMask,       32'd0);
    chk("reset_ldready", 32'(bus.ldReady),   32'd1);
    @(posedge CLK);
    #1 rstControl = 1'b1;

    // Table: ALU path, load into idle port, rd=0 load, ALU/load collision.
    tbl[0]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        32'h0,   1);
    tbl[1]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        32'h0,   1);
    tbl[2]  = mk(1, 5'd0, 32'h11111111, 0, 5'd0, 32'h0,    1, 5'd5, 32'hDEADBEEF, 32'h0,   1);
    tbl[3]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd5, 32'hDEADBEEF, 32'h0,   1);
    tbl[4]  = mk(0, 5'd0, 32'h0,        1, 5'd7, 32'h1234, 0, 5'd5, 32'hDEADBEEF, 32'h0,   1);
    tbl[5]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd5, 32'hDEADBEEF, 32'h80,  1);
    tbl[6]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd7, 32'h1234,     32'h0,   1);
    tbl[7]  = mk(0, 5'd0, 32'h0,        1, 5'd0, 32'h5555, 0, 5'd7, 32'h1234,     32'h0,   1);
    tbl[8]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd7, 32'h1234,     32'h0,   1);
    tbl[9]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd7, 32'h1234,     32'h0,   1);
    tbl[10] = mk(1, 5'd3, 32'hA5A5,     1, 5'd9, 32'h99,   0, 5'd7, 32'h1234,     32'h0,   1);
    tbl[11] = mk(1, 5'd4, 32'hB4,       0, 5'd0, 32'h0,    1, 5'd3, 32'hA5A5,     32'h200, 1);
    tbl[12] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd4, 32'hB4,       32'h200, 1);
    tbl[13] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    1, 5'd9, 32'h99,       32'h0,   1);
    tbl[14] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 5'd9, 32'h99,       32'h0,   1);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].lv, tbl[i].lr, tbl[i].ld);
      #1;
      chk($sformatf("tbl%0d_we", i),      32'(bus.WE),      32'(tbl[i].we));
      chk($sformatf("tbl%0d_rd", i),      32'(bus.rd),      32'(tbl[i].rd));
      chk($sformatf("tbl%0d_wb", i),      bus.writeBack,    tbl[i].wb);
      chk($sformatf("tbl%0d_busy", i),    bus.busyMask,     tbl[i].busy);
      chk($sformatf("tbl%0d_ldready", i), 32'(bus.ldReady), 32'(tbl[i].lrdy));
      tick();
    end

    // Fill the FIFO behind a busy ALU, then observe the forced bubble and drain.
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      av = (c <= 9);
      ad = (c == 9) ? 32'h108 : (32'h100 + 32'(c));
      lv = (c <= 3);
      lr = 5'(8 + c);
      drive(av, 5'd1, ad, lv, lr, 32'h800 + 32'(c));
      #1;
      case (c)
        3: chk("fill_ldready_3", 32'(bus.ldReady), 32'd1);
        4: begin
          chk("fill_ldready_full", 32'(bus.ldReady),  32'd0);
          chk("fill_busy",         bus.busyMask,      32'hF00);
        end
        7: chk("starve_no_stall_early", 32'(bus.stallALU), 32'd0);
        8: begin
          chk("starve_stall",    32'(bus.stallALU), 32'd1);
          chk("starve_aluready", 32'(bus.aluReady), 32'd0);
        end
        9: begin
          chk("starve_stall_off", 32'(bus.stallALU), 32'd0);
          chk("starve_pop_we",    32'(bus.WE),       32'd1);
          chk("starve_pop_rd",    32'(bus.rd),       32'd8);
          chk("starve_pop_wb",    bus.writeBack,     32'h800);
          chk("starve_busy",      bus.busyMask,      32'hE00);
        end
        10: begin
          chk("held_alu_rd", 32'(bus.rd),   32'd1);
          chk("held_alu_wb", bus.writeBack, 32'h108);
        end
        11: chk("drain_rd9",  32'(bus.rd), 32'd9);
        12: chk("drain_rd10", 32'(bus.rd), 32'd10);
        13: chk("drain_wb11", bus.writeBack, 32'h803);
        14: begin
          chk("drain_we_off", 32'(bus.WE),   32'd0);
          chk("drain_busy",   bus.busyMask, 32'd0);
        end
        default: ;
      endcase
      tick();
    end

    // Asynchronous reset with three loads queued.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd1, 32'hC0 + 32'(c), 1'b1, 5'(12 + c), 32'hD0 + 32'(c));
      #1;
      tick();
    end
    drive(1'b1, 5'd1, 32'hC3, 1'b0, 5'd0, 32'd0);
    #1;
    chk("prerst_busy", bus.busyMask, 32'h7000);
    #2 rstControl = 1'b0;
    #1;
    chk("arst_we",      32'(bus.WE),        32'd0);
    chk("arst_rd",      32'(bus.rd),        32'd0);
    chk("arst_wb",      bus.writeBack,      32'd0);
    chk("arst_busy",    bus.busyMask,       32'd0);
    chk("arst_ldready", 32'(bus.ldReady),   32'd1);
    chk("arst_stall",   32'(bus.stallALU),  32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge CLK);
    #1 rstControl = 1'b1;
    model_clear();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      chk($sformatf("postrst_we%0d", c),   32'(bus.WE),  32'd0);
      chk($sformatf("postrst_busy%0d", c), bus.busyMask, 32'd0);
      tick();
    end

    // Random traffic against the queue-based reference model.
    held = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      if (!held) begin
        av = ($urandom_range(0, 4) != 0);
        ar = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ad = $urandom();
      end
      lv = ($urandom_range(0, 1) == 1);
      lr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ld = $urandom();
      drive(av, ar, ad, lv, lr, ld);
      #1;
      chk("rnd_we",       32'(bus.WE),        32'(m_we));
      chk("rnd_rd",       32'(bus.rd),        32'(m_rd));
      chk("rnd_wb",       bus.writeBack,      m_wb);
      chk("rnd_stall",    32'(bus.stallALU),  32'(m_stall));
      chk("rnd_aluready", 32'(bus.aluReady),  32'(!m_stall));
      chk("rnd_ldready",  32'(bus.ldReady),   32'(q.size() < DEPTH));
      chk("rnd_busy",     bus.busyMask,       model_busy());
      held = av && m_stall;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
